// File: rtl/timed_init_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// init_seq_pkg
// Shared definitions for the timed init sequencer:
//   - FSM state encoding (IDLE / RUN / DONE)
//   - default delay and value constants
//   - counter width helper
// ---------------------------------------------------------------------------
package init_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int         DEF_WIDTH = 3;
    localparam int         DEF_D1    = 10;
    localparam int         DEF_D2    = 20;
    localparam int         DEF_D3    = 30;
    localparam logic [2:0] DEF_V3    = 3'b001;
    localparam logic [2:0] DEF_V4    = 3'b100;
    localparam logic [2:0] DEF_V5    = 3'b101;

    // Counter must hold D2+D3, the value it reaches on the final RUN edge.
    function automatic int cnt_width(input int d2, input int d3);
        return $clog2(d2 + d3 + 1);
    endfunction

endpackage

// File: rtl/timed_init_sequencer_if.sv
// ---------------------------------------------------------------------------
// timed_init_sequencer_if
// Groups the request/capture inputs and the sequence outputs of the
// sequencer.
//   master : drives start/in1/in2, observes out1..out5/busy/done
//   slave  : the sequencer itself
// ---------------------------------------------------------------------------
interface timed_init_sequencer_if #(
    parameter int WIDTH = 3
);
    logic             start;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic [WIDTH-1:0] out1;
    logic [WIDTH-1:0] out2;
    logic [WIDTH-1:0] out3;
    logic [WIDTH-1:0] out4;
    logic [WIDTH-1:0] out5;
    logic             busy;
    logic             done;

    modport master (
        output start, in1, in2,
        input  out1, out2, out3, out4, out5, busy, done
    );

    modport slave (
        input  start, in1, in2,
        output out1, out2, out3, out4, out5, busy, done
    );
endinterface

// File: rtl/timed_init_sequencer_event_timer.sv
// ---------------------------------------------------------------------------
// event_timer
// Cycle counter plus the three compare strobes used by the sequencer.
// Ports:
//   clk, rst_n   : clock, synchronous active-low reset
//   i_clr        : clear the count (sequence start)
//   i_en         : count up one per edge (RUN)
//   o_hit_d1     : the coming edge is offset D1
//   o_hit_d2     : the coming edge is offset D2
//   o_hit_end    : the coming edge is offset D2+D3 (sequence end)
// ---------------------------------------------------------------------------
module event_timer
    import init_seq_pkg::*;
#(
    parameter int D1 = DEF_D1,
    parameter int D2 = DEF_D2,
    parameter int D3 = DEF_D3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_hit_d1,
    output logic o_hit_d2,
    output logic o_hit_end
);

    localparam int CW = cnt_width(D2, D3);

    // Compare in 32 bits so an oversized D1 can never alias onto a small count.
    localparam logic [31:0] L_D1  = 32'(D1);
    localparam logic [31:0] L_D2  = 32'(D2);
    localparam logic [31:0] L_END = 32'(D2 + D3);

    logic [CW-1:0] r_cnt;
    logic [31:0]   w_cnt_plus1;

    // Count register: cleared on start, advanced while enabled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= {CW{1'b0}};
        end else if (i_clr) begin
            r_cnt <= {CW{1'b0}};
        end else if (i_en) begin
            r_cnt <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
        end else begin
            r_cnt <= r_cnt;
        end
    end

    // Strobes look at cnt+1 so they fire on the edge that completes the offset.
    assign w_cnt_plus1 = 32'(r_cnt) + 32'd1;
    assign o_hit_d1    = (w_cnt_plus1 == L_D1);
    assign o_hit_d2    = (w_cnt_plus1 == L_D2);
    assign o_hit_end   = (w_cnt_plus1 == L_END);

endmodule

// File: rtl/timed_init_sequencer.sv
// ---------------------------------------------------------------------------
// timed_init_sequencer
// On start (in IDLE or DONE) captures in1/in2 onto out1/out2, then writes
// V3 to out3 at offset D1, V4 to out4 at offset D2 and V5 to out5 at offset
// D2+D3, where the sequence completes. All outputs are registered.
// Ports:
//   clk    : single rising-edge clock
//   rst_n  : synchronous active-low reset, highest priority
//   bus    : slave side of timed_init_sequencer_if
//            (start, in1, in2 in; out1..out5, busy, done out)
// ---------------------------------------------------------------------------
module timed_init_sequencer
    import init_seq_pkg::*;
#(
    parameter int               WIDTH = DEF_WIDTH,
    parameter int               D1    = DEF_D1,
    parameter int               D2    = DEF_D2,
    parameter int               D3    = DEF_D3,
    parameter logic [WIDTH-1:0] V3    = WIDTH'(DEF_V3),
    parameter logic [WIDTH-1:0] V4    = WIDTH'(DEF_V4),
    parameter logic [WIDTH-1:0] V5    = WIDTH'(DEF_V5)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    timed_init_sequencer_if.slave  bus
);

    state_e           r_state;
    state_e           w_next_state;

    logic [WIDTH-1:0] r_out1, r_out2, r_out3, r_out4, r_out5;
    logic             r_busy, r_done;
    logic [WIDTH-1:0] w_out1_nxt, w_out2_nxt, w_out3_nxt, w_out4_nxt, w_out5_nxt;
    logic             w_busy_nxt, w_done_nxt;

    logic             w_accept_start;
    logic             w_run;
    logic             w_hit_d1, w_hit_d2, w_hit_end;

    // start is only honoured outside RUN; in RUN it is ignored entirely.
    assign w_accept_start = bus.start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_run          = (r_state == ST_RUN);

    event_timer #(
        .D1 (D1),
        .D2 (D2),
        .D3 (D3)
    ) u_event_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clr     (w_accept_start),
        .i_en      (w_run),
        .o_hit_d1  (w_hit_d1),
        .o_hit_d2  (w_hit_d2),
        .o_hit_end (w_hit_end)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_next_state = ST_RUN;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (w_hit_end) begin
                    w_next_state = ST_DONE;
                end else begin
                    w_next_state = ST_RUN;
                end
            end
            ST_DONE: begin
                if (bus.start) begin
                    w_next_state = ST_RUN;
                end else begin
                    w_next_state = ST_DONE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Output next-value logic; everything holds unless an event applies.
    always_comb begin
        w_out1_nxt = r_out1;
        w_out2_nxt = r_out2;
        w_out3_nxt = r_out3;
        w_out4_nxt = r_out4;
        w_out5_nxt = r_out5;
        w_busy_nxt = r_busy;
        w_done_nxt = r_done;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    w_out1_nxt = bus.in1;
                    w_out2_nxt = bus.in2;
                    w_out3_nxt = {WIDTH{1'b0}};
                    w_out4_nxt = {WIDTH{1'b0}};
                    w_out5_nxt = {WIDTH{1'b0}};
                    w_busy_nxt = 1'b1;
                    w_done_nxt = 1'b0;
                end else begin
                    w_busy_nxt = r_busy;
                end
            end
            ST_RUN: begin
                // The three chains are independent; coincident hits all apply.
                if (w_hit_d1) begin
                    w_out3_nxt = V3;
                end else begin
                    w_out3_nxt = r_out3;
                end
                if (w_hit_d2) begin
                    w_out4_nxt = V4;
                end else begin
                    w_out4_nxt = r_out4;
                end
                if (w_hit_end) begin
                    w_out5_nxt = V5;
                    w_busy_nxt = 1'b0;
                    w_done_nxt = 1'b1;
                end else begin
                    w_out5_nxt = r_out5;
                end
            end
            default: begin
                w_busy_nxt = r_busy;
            end
        endcase
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out1 <= {WIDTH{1'b0}};
            r_out2 <= {WIDTH{1'b0}};
            r_out3 <= {WIDTH{1'b0}};
            r_out4 <= {WIDTH{1'b0}};
            r_out5 <= {WIDTH{1'b0}};
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_out1 <= w_out1_nxt;
            r_out2 <= w_out2_nxt;
            r_out3 <= w_out3_nxt;
            r_out4 <= w_out4_nxt;
            r_out5 <= w_out5_nxt;
            r_busy <= w_busy_nxt;
            r_done <= w_done_nxt;
        end
    end

    assign bus.out1 = r_out1;
    assign bus.out2 = r_out2;
    assign bus.out3 = r_out3;
    assign bus.out4 = r_out4;
    assign bus.out5 = r_out5;
    assign bus.busy = r_busy;
    assign bus.done = r_done;

endmodule

// File: tb/tb_timed_init_sequencer.sv
// ---------------------------------------------------------------------------
// tb_timed_init_sequencer
// Three sequencers share one stimulus stream:
//   A : default offsets (10 / 20 / 30)
//   B : D1=D2=4, D3=2   (coincident out3/out4 update)
//   C : D1=9, D2=3, D3=2 (D1 beyond the end, out3 never written)
// A time-based model (elapsed cycles since the accepted start) predicts
// every output on every cycle; directed literal checks pin the model.
// ---------------------------------------------------------------------------
module tb_timed_init_sequencer;

    logic       clk = 1'b1;
    logic       rst_n;
    logic       s_start;
    logic [2:0] s_in1;
    logic [2:0] s_in2;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    timed_init_sequencer_if #(.WIDTH(3)) if_a ();
    timed_init_sequencer_if #(.WIDTH(3)) if_b ();
    timed_init_sequencer_if #(.WIDTH(3)) if_c ();

    assign if_a.start = s_start;  assign if_a.in1 = s_in1;  assign if_a.in2 = s_in2;
    assign if_b.start = s_start;  assign if_b.in1 = s_in1;  assign if_b.in2 = s_in2;
    assign if_c.start = s_start;  assign if_c.in1 = s_in1;  assign if_c.in2 = s_in2;

    timed_init_sequencer #(.WIDTH(3)) dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
    timed_init_sequencer #(.WIDTH(3), .D1(4), .D2(4), .D3(2)) dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b));
    timed_init_sequencer #(.WIDTH(3), .D1(9), .D2(3), .D3(2)) dut_c (.clk(clk), .rst_n(rst_n), .bus(if_c));

    // {out1,out2,out3,out4,out5,busy,done}
    logic [16:0] act_pk [3];
    assign act_pk[0] = {if_a.out1, if_a.out2, if_a.out3, if_a.out4, if_a.out5, if_a.busy, if_a.done};
    assign act_pk[1] = {if_b.out1, if_b.out2, if_b.out3, if_b.out4, if_b.out5, if_b.busy, if_b.done};
    assign act_pk[2] = {if_c.out1, if_c.out2, if_c.out3, if_c.out4, if_c.out5, if_c.busy, if_c.done};

    int    p_d1 [3] = '{10, 4, 9};
    int    p_d2 [3] = '{20, 4, 3};
    int    p_d3 [3] = '{30, 2, 2};
    string p_nm [3] = '{"A", "B", "C"};
    localparam logic [2:0] EV3 = 3'b001;
    localparam logic [2:0] EV4 = 3'b100;
    localparam logic [2:0] EV5 = 3'b101;

    // Model state: last accepted start edge and captured words per instance.
    int         cyc = 0;
    bit         m_known = 1'b0;
    bit         m_valid [3] = '{1'b0, 1'b0, 1'b0};
    int         m_t0 [3] = '{0, 0, 0};
    logic [2:0] m_c1 [3];
    logic [2:0] m_c2 [3];

    task automatic chk(input string nm, input logic [2:0] act, input logic [2:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Expected outputs after edge number cyc, from elapsed time since start.
    function automatic logic [16:0] model_outs(input int i);
        int         k;
        int         l;
        logic [2:0] o3, o4, o5;
        if (!m_valid[i]) return 17'd0;
        k  = cyc - m_t0[i];
        l  = p_d2[i] + p_d3[i];
        o3 = (k >= p_d1[i] && p_d1[i] <= l) ? EV3 : 3'd0;
        o4 = (k >= p_d2[i]) ? EV4 : 3'd0;
        o5 = (k >= l) ? EV5 : 3'd0;
        return {m_c1[i], m_c2[i], o3, o4, o5, (k < l), (k >= l)};
    endfunction

    // Compare process: check all outputs, then advance the model by the
    // inputs that the next rising edge will sample.
    initial begin
        logic [16:0] e;
        logic [16:0] a;
        forever begin
            @(negedge clk);
            if (m_known) begin
                for (int i = 0; i < 3; i++) begin
                    e = model_outs(i);
                    a = act_pk[i];
                    chk({p_nm[i], ".out1"}, a[16:14], e[16:14]);
                    chk({p_nm[i], ".out2"}, a[13:11], e[13:11]);
                    chk({p_nm[i], ".out3"}, a[10:8],  e[10:8]);
                    chk({p_nm[i], ".out4"}, a[7:5],   e[7:5]);
                    chk({p_nm[i], ".out5"}, a[4:2],   e[4:2]);
                    chk({p_nm[i], ".busy"}, {2'b00, a[1]}, {2'b00, e[1]});
                    chk({p_nm[i], ".done"}, {2'b00, a[0]}, {2'b00, e[0]});
                end
            end
            cyc++;
            for (int i = 0; i < 3; i++) begin
                if (!rst_n) begin
                    m_valid[i] = 1'b0;
                end else if (s_start && (!m_valid[i] || (cyc - m_t0[i]) >= p_d2[i] + p_d3[i] + 1)) begin
                    m_valid[i] = 1'b1;
                    m_t0[i]    = cyc;
                    m_c1[i]    = s_in1;
                    m_c2[i]    = s_in2;
                end
            end
            if (!rst_n) m_known = 1'b1;
        end
    end

    // Advance n rising edges and settle just past the last one.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        s_start = 1'b0;
        s_in1   = 3'd0;
        s_in2   = 3'd0;
        tick(2);
        rst_n = 1'b1;
        tick(5);
        chk("idle_busy", {2'b00, if_a.busy}, 3'd0);
        chk("idle_done", {2'b00, if_a.done}, 3'd0);
        chk("idle_out1", if_a.out1, 3'd0);

        // Default sequence; after tick(1) below we are just past T0 (k=0).
        s_in1 = 3'b011; s_in2 = 3'b110; s_start = 1'b1;
        tick(1);
        s_start = 1'b0;
        chk("seq_out1", if_a.out1, 3'd3);
        chk("seq_out2", if_a.out2, 3'd6);
        chk("seq_busy", {2'b00, if_a.busy}, 3'd1);
        tick(3);                                   // k=3
        chk("coin_out3_pre", if_b.out3, 3'd0);
        chk("coin_out4_pre", if_b.out4, 3'd0);
        tick(1);                                   // k=4
        chk("coin_out3", if_b.out3, 3'd1);
        chk("coin_out4", if_b.out4, 3'd4);
        chk("coin_done_pre", {2'b00, if_b.done}, 3'd0);
        tick(2);                                   // k=6
        chk("coin_out5", if_b.out5, 3'd5);
        chk("coin_done", {2'b00, if_b.done}, 3'd1);
        chk("late_d1_out3", if_c.out3, 3'd0);
        chk("late_d1_done", {2'b00, if_c.done}, 3'd1);
        tick(3);                                   // k=9
        chk("out3_pre", if_a.out3, 3'd0);
        tick(1);                                   // k=10
        chk("out3_at_d1", if_a.out3, 3'd1);
        tick(4);                                   // k=14: start sampled at T0+15
        s_in1 = 3'b111; s_start = 1'b1;
        tick(1);
        s_start = 1'b0;
        tick(1);                                   // k=16
        chk("run_start_ignored", if_a.out1, 3'd3);
        tick(3);                                   // k=19
        chk("out4_pre", if_a.out4, 3'd0);
        tick(1);                                   // k=20
        chk("out4_at_d2", if_a.out4, 3'd4);
        tick(29);                                  // k=49
        chk("busy_pre_end", {2'b00, if_a.busy}, 3'd1);
        chk("done_pre_end", {2'b00, if_a.done}, 3'd0);
        tick(1);                                   // k=50
        chk("end_done", {2'b00, if_a.done}, 3'd1);
        chk("end_out5", if_a.out5, 3'd5);
        chk("end_busy", {2'b00, if_a.busy}, 3'd0);

        // Restart from DONE.
        tick(3);
        s_in1 = 3'b001; s_in2 = 3'b010; s_start = 1'b1;
        tick(1);
        s_start = 1'b0;
        chk("restart_out1", if_a.out1, 3'd1);
        chk("restart_out2", if_a.out2, 3'd2);
        chk("restart_out3", if_a.out3, 3'd0);
        chk("restart_out5", if_a.out5, 3'd0);
        chk("restart_done", {2'b00, if_a.done}, 3'd0);

        // Reset mid-run at T0'+25.
        tick(24);
        rst_n = 1'b0;
        tick(1);
        chk("midrst_out1", if_a.out1, 3'd0);
        chk("midrst_out4", if_a.out4, 3'd0);
        chk("midrst_busy", {2'b00, if_a.busy}, 3'd0);
        rst_n = 1'b1;
        s_in1 = 3'b101; s_in2 = 3'b100; s_start = 1'b1;
        tick(1);
        s_start = 1'b0;
        tick(49);
        chk("fresh_done_pre", {2'b00, if_a.done}, 3'd0);
        tick(1);
        chk("fresh_done", {2'b00, if_a.done}, 3'd1);

        // start held high: restart in the first DONE cycle, repeatedly.
        s_start = 1'b1;
        tick(130);
        s_start = 1'b0;
        tick(3);

        // Randomized stimulus: pulses, short levels, occasional reset.
        for (int n = 0; n < 3000; n++) begin
            s_start = ($urandom_range(0, 11) == 0) || (s_start && $urandom_range(0, 3) != 0);
            s_in1   = 3'($urandom);
            s_in2   = 3'($urandom);
            rst_n   = ($urandom_range(0, 399) != 0);
            tick(1);
        end
        rst_n   = 1'b1;
        s_start = 1'b0;
        tick(2);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
